ddr_write_buffer: RTL
=====================

DDR_WRITE_BUFFER -- requirements
Module: ddr_write_buffer

Interface
REQ-001 Parameter g_BUFF_AWIDTH, default 10: buffer address width; depth is 2**g_BUFF_AWIDTH words.
REQ-002 Parameter g_DWIDTH, default 64: data word width in bits.
REQ-003 Parameter g_BURST_LEN, default 16: words per DDR write burst; must be a power of two, at most depth/2.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock; all logic on the rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 we_i  in  1  write strobe for wr_data_i.
REQ-008 wr_data_i  in  g_DWIDTH  pixel-packed write word.
REQ-009 eol_i  in  1  end-of-line pulse; marks the current contents as a final partial burst.
REQ-010 flush_i  in  1  frame-start pulse; discards all contents.
REQ-011 rd_en_i  in  1  pop one word, issued by the DDR write master.
REQ-012 rd_data_o  out  g_DWIDTH  read word.
REQ-013 rd_valid_o  out  1  rd_data_o valid this cycle.
REQ-014 burst_rdy_o  out  1  a burst is available.
REQ-015 burst_len_o  out  g_BUFF_AWIDTH+1  words in the available burst.
REQ-016 level_o  out  g_BUFF_AWIDTH+1  current word count.
REQ-017 full_o, empty_o  out  1 each  buffer status.
REQ-018 overflow_o, underflow_o  out  1 each  sticky error flags.

Function
REQ-019 Write and read pointers are g_BUFF_AWIDTH bits wide and wrap modulo depth.
REQ-020 A write is accepted when we_i=1 and full_o=0.
REQ-021 A write with full_o=1 is dropped and sets overflow_o, even if a read occurs in the same cycle.
REQ-022 A read is accepted when rd_en_i=1 and empty_o=0.
REQ-023 A read with empty_o=1 is ignored and sets underflow_o.
REQ-024 Read latency is 1 cycle: data and rd_valid_o=1 appear on the cycle after the accepted rd_en_i, from a registered read address.
REQ-025 level_o changes as follows: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-026 full_o = (level_o == depth); empty_o = (level_o == 0); both derived from registered level.
REQ-027 A simultaneous write and read at the same address while level_o=0 is impossible, because the read is rejected when empty.
REQ-028 An eol_i pulse sets tail_pend when level_o>0 after that cycle's write.
REQ-029 tail_pend clears when level_o reaches 0.
REQ-030 The burst FSM has three states: IDLE, READY, ACTIVE.
REQ-031 IDLE -> READY when level_o >= g_BURST_LEN, or when tail_pend=1 and level_o>0.
REQ-032 On entry to READY, burst_len_o latches min(level_o, g_BURST_LEN).
REQ-033 burst_rdy_o=1 only in READY.
REQ-034 READY -> ACTIVE on the first accepted read.
REQ-035 In ACTIVE, a count decrements per accepted read; at 0 the FSM returns to IDLE.
REQ-036 IDLE re-evaluates on the following cycle, so back-to-back bursts have exactly 1 idle cycle.
REQ-037 burst_len_o holds its value until the next READY entry.
REQ-038 A flush_i pulse resets pointers, level, tail_pend, the FSM (to IDLE) and rd_valid_o on the next edge; RAM contents are untouched.
REQ-039 flush_i has priority over we_i, rd_en_i and eol_i in the same cycle.
REQ-040 overflow_o and underflow_o are cleared only by reset_i or flush_i.

Reset
REQ-041 reset_i=1 forces: pointers=0, level_o=0, empty_o=1, full_o=0, burst_rdy_o=0, burst_len_o=0, rd_valid_o=0, overflow_o=0, underflow_o=0, FSM=IDLE, tail_pend=0.
REQ-042 rd_data_o is unreset and is don't-care while rd_valid_o=0.
REQ-043 Asserting reset_i mid-burst abandons the burst; no further rd_valid_o appears after the reset cycle.

Structure
REQ-044 The FSM state encoding and the default burst length constant belong in the shared video package.
REQ-045 The storage SHALL be one sub-module, ddr_wbuf_ram: single-clock simple dual-port memory, LSRAM style, with a registered read address.

Verification
Bench parameters: g_BUFF_AWIDTH=4 (depth 16), g_BURST_LEN=4.
REQ-046 Bench SHALL check basic burst:
- 4 writes 0x1..0x4 -> burst_rdy_o=1 with burst_len_o=4.
- 4 reads -> data 1,2,3,4 each 1 cycle after rd_en_i.
- level_o=0 and empty_o=1 at the end.
REQ-047 Bench SHALL check end-of-line tail:
- 3 writes then eol_i -> burst_rdy_o=1 with burst_len_o=3.
- After 3 reads -> IDLE, tail_pend=0.
REQ-048 Bench SHALL check overflow:
- 17 writes with no reads -> full_o=1 after 16 writes, 17th word dropped, overflow_o=1, level_o=16.
REQ-049 Bench SHALL check wrap-around with simultaneous access:
- Stream 40 words with concurrent reads -> readback in order across pointer wrap.
- level_o never exceeds 16 and is unchanged on simultaneous-access cycles.
REQ-050 Bench SHALL check underflow and flush:
- rd_en_i when empty -> underflow_o=1 and no rd_valid_o.
- flush_i during ACTIVE -> next cycle level_o=0, burst_rdy_o=0, underflow_o=0.
REQ-051 Bench SHALL check reset mid-burst:
- reset_i during ACTIVE -> all outputs at their REQ-041 values next cycle.

Source files
------------

// File: rtl/ddr_write_buffer_pkg.sv
// Shared definitions for the DDR write buffer: burst FSM encoding and defaults.
package ddr_write_buffer_pkg;

    // Burst handshake states seen by the DDR write master
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_ACTIVE = 2'd2
    } burst_state_e;

    localparam int unsigned C_DEF_BUFF_AWIDTH = 10;
    localparam int unsigned C_DEF_DWIDTH      = 64;
    localparam int unsigned C_DEF_BURST_LEN   = 16;

endpackage : ddr_write_buffer_pkg

// File: rtl/ddr_wbuf_ram.sv
// Single-clock simple dual-port storage with a registered read address.
module ddr_wbuf_ram #(
    parameter int unsigned g_AWIDTH = 10,
    parameter int unsigned g_DWIDTH = 64
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [g_AWIDTH-1:0] waddr_i,
    input  logic [g_DWIDTH-1:0] wdata_i,
    input  logic                re_i,
    input  logic [g_AWIDTH-1:0] raddr_i,
    output logic [g_DWIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << g_AWIDTH;

    logic [g_DWIDTH-1:0] mem_q [DEPTH];
    logic [g_AWIDTH-1:0] raddr_q;

    // Write port and read-address register; contents are deliberately unreset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule : ddr_wbuf_ram

// File: rtl/ddr_write_buffer.sv
// Line buffer between pixel writer and DDR write master; announces bursts.
module ddr_write_buffer
    import ddr_write_buffer_pkg::*;
#(
    parameter int unsigned g_BUFF_AWIDTH = C_DEF_BUFF_AWIDTH,
    parameter int unsigned g_DWIDTH      = C_DEF_DWIDTH,
    parameter int unsigned g_BURST_LEN   = C_DEF_BURST_LEN
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     we_i,
    input  logic [g_DWIDTH-1:0]      wr_data_i,
    input  logic                     eol_i,
    input  logic                     flush_i,
    input  logic                     rd_en_i,
    output logic [g_DWIDTH-1:0]      rd_data_o,
    output logic                     rd_valid_o,
    output logic                     burst_rdy_o,
    output logic [g_BUFF_AWIDTH:0]   burst_len_o,
    output logic [g_BUFF_AWIDTH:0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned LW    = g_BUFF_AWIDTH + 1;
    localparam int unsigned DEPTH = 1 << g_BUFF_AWIDTH;

    localparam logic [LW-1:0] C_DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] C_BURST_L = LW'(g_BURST_LEN);

    logic [g_BUFF_AWIDTH-1:0] wptr_q, wptr_d;
    logic [g_BUFF_AWIDTH-1:0] rptr_q, rptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     tail_q, tail_d;
    logic                     full_q, empty_q;
    logic                     ovf_q, unf_q;
    logic                     rd_valid_q;
    burst_state_e             state_q;
    logic                     rdy_q;
    logic [LW-1:0]            blen_q;
    logic [LW-1:0]            cnt_q;

    logic                     wr_acc_c;
    logic                     rd_acc_c;

    // Accepted accesses; a flush cycle accepts nothing
    assign wr_acc_c = we_i    & ~full_q  & ~flush_i;
    assign rd_acc_c = rd_en_i & ~empty_q & ~flush_i;

    // Next pointers, fill level and tail-pending flag
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        tail_d  = tail_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            tail_d  = 1'b0;
        end else begin
            if (wr_acc_c) begin
                wptr_d = wptr_q + g_BUFF_AWIDTH'(1);
            end
            if (rd_acc_c) begin
                rptr_d = rptr_q + g_BUFF_AWIDTH'(1);
            end
            if (wr_acc_c && !rd_acc_c) begin
                level_d = level_q + LW'(1);
            end else if (rd_acc_c && !wr_acc_c) begin
                level_d = level_q - LW'(1);
            end
            if (eol_i && (level_d != '0)) begin
                tail_d = 1'b1;
            end else if (level_d == '0) begin
                tail_d = 1'b0;
            end
        end
    end

    // Datapath registers, status flags and sticky error flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            tail_q     <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            tail_q     <= tail_d;
            full_q     <= (level_d == C_DEPTH_L);
            empty_q    <= (level_d == '0);
            rd_valid_q <= rd_acc_c;
            if (flush_i) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (we_i && full_q) begin
                    ovf_q <= 1'b1;
                end
                if (rd_en_i && empty_q) begin
                    unf_q <= 1'b1;
                end
            end
        end
    end

    // Burst announce FSM: waits for a full burst or a pending line tail
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            blen_q  <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((level_q >= C_BURST_L) || (tail_q && (level_q != '0))) begin
                        state_q <= ST_READY;
                        rdy_q   <= 1'b1;
                        if (level_q >= C_BURST_L) begin
                            blen_q <= C_BURST_L;
                            cnt_q  <= C_BURST_L;
                        end else begin
                            blen_q <= level_q;
                            cnt_q  <= level_q;
                        end
                    end
                end
                ST_READY: begin
                    if (rd_acc_c) begin
                        rdy_q <= 1'b0;
                        cnt_q <= cnt_q - LW'(1);
                        if (cnt_q == LW'(1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (rd_acc_c) begin
                        cnt_q <= cnt_q - LW'(1);
                        if (cnt_q == LW'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Storage; read address register gives the one-cycle read latency
    ddr_wbuf_ram #(
        .g_AWIDTH (g_BUFF_AWIDTH),
        .g_DWIDTH (g_DWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc_c),
        .waddr_i (wptr_q),
        .wdata_i (wr_data_i),
        .re_i    (rd_acc_c),
        .raddr_i (rptr_q),
        .rdata_o (rd_data_o)
    );

    assign rd_valid_o  = rd_valid_q;
    assign burst_rdy_o = rdy_q;
    assign burst_len_o = blen_q;
    assign level_o     = level_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule : ddr_write_buffer
